ibex_l2_rf_xfer: RTL
====================

Name: ibex_l2_rf_xfer

Overview:
Transfer engine that initiates accesses on the single-port L2 register file (addr/wdata/we, combinational read) and on a core register-file side port. On request it moves a contiguous register range in one of two directions: spill (core RF -> L2) or fill (L2 -> core RF). It moves one register per cycle, can be stalled and aborted, and reports completion. It sits between the core's context save/restore control and the L2 register file.

Parameters:
DataWidth, 32, register width in bits
NumWords, 28, L2 depth; valid register addresses are 1..NumWords-1 (address 0 is never stored)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  transfer request valid
req_ready_o  output  1  engine can accept a request (IDLE)
req_dir_i  input  1  direction: 0 = spill (core RF -> L2), 1 = fill (L2 -> core RF)
req_first_i  input  5  first register index
req_last_i  input  5  last register index (inclusive)
stall_i  input  1  pause transfers this cycle
abort_i  input  1  terminate the active transfer
rf_raddr_o  output  5  core RF read address (spill)
rf_rdata_i  input  DataWidth  core RF read data, combinational from rf_raddr_o
rf_waddr_o  output  5  core RF write address (fill)
rf_wdata_o  output  DataWidth  core RF write data
rf_we_o  output  1  core RF write enable
l2_addr_o  output  5  L2 address
l2_wdata_o  output  DataWidth  L2 write data
l2_rdata_i  input  DataWidth  L2 read data, combinational from l2_addr_o
l2_we_o  output  1  L2 write enable
done_o  output  1  one-cycle completion pulse
err_o  output  1  valid with done_o: request was rejected
aborted_o  output  1  valid with done_o: transfer was aborted
xfer_cnt_o  output  5  registers moved by the last/current transfer

Behaviour:
- Reset (asynchronous): state IDLE, idx = 0, xfer_cnt = 0, all flags 0.
  - All outputs 0 except req_ready_o = 1.
  - No write enable is asserted during or after reset; a reset mid-transfer discards the transfer and emits no done_o.
- States:
  - IDLE: req_ready_o = 1. On req_valid_i, validate the range.
    - Invalid: first == 0, last == 0, first > last, or last >= NumWords. Go to DONE with err_o = 1; no writes occur.
    - Valid: idx <= first, latch dir, xfer_cnt <= 0, go to XFER.
  - XFER: req_ready_o = 0. Priority is abort_i > stall_i > transfer.
    - abort_i: no write this cycle; go to DONE with aborted_o = 1.
    - stall_i: hold idx; both write enables low.
    - Otherwise, perform one transfer at idx, then xfer_cnt++. If idx == last go to DONE, else idx++.
  - DONE: done_o = 1 for exactly one cycle; err_o and aborted_o are driven; req_ready_o = 0; next state IDLE.
- Spill transfer cycle:
  - rf_raddr_o = idx, l2_addr_o = idx.
  - l2_wdata_o = rf_rdata_i, l2_we_o = 1, rf_we_o = 0.
- Fill transfer cycle:
  - l2_addr_o = idx, rf_waddr_o = idx.
  - rf_wdata_o = l2_rdata_i, rf_we_o = 1, l2_we_o = 0.
- Addresses are driven as idx throughout XFER, including stall cycles. In IDLE and DONE, all address, data and write-enable outputs are 0.
- Write data is combinational pass-through gated by the write enable; it is 0 when the enable is low.
- Latency: request accepted in cycle 0; N = last-first+1 writes occur in cycles 1..N (no stalls); done_o in cycle N+1; req_ready_o high again in cycle N+2. Each stall cycle adds one cycle.
- xfer_cnt_o is registered and holds after DONE until the next accepted request. On abort it reports the writes completed.
- err_o and aborted_o are 0 outside DONE.
- abort_i and stall_i are ignored outside XFER.

Decomposition:
- ibex_pkg additions:
  - typedef enum logic {L2_XFER_SPILL = 1'b0, L2_XFER_FILL = 1'b1} l2_xfer_dir_e
  - typedef enum logic [1:0] {L2X_IDLE, L2X_XFER, L2X_DONE} l2_xfer_state_e
- No sub-module. Range validation and the datapath muxing are small enough to stay inline.

Test Plan:
- Spill 3..5, L2 model with combinational read, core RF holding 0xA0000003..0xA0000005:
  -> l2_we_o high in cycles 1-3 at addresses 3,4,5; L2 then contains those values; done_o in cycle 4; err_o = 0; xfer_cnt_o = 3.
- Fill 1..27 after preloading L2 with 0x100+i:
  -> 27 rf_we_o pulses, address i with data 0x100+i; done_o in cycle 28; l2_we_o never high.
- Invalid requests (first = 0; first = 7 with last = 6; last = 28):
  -> done_o one cycle after acceptance with err_o = 1; no write enable; xfer_cnt_o = 0.
- Spill 10..12 with stall_i high in cycles 2-3:
  -> writes at addresses 10, 11, 12 in cycles 1, 4, 5; l2_addr_o = 11 held during the stall; done_o in cycle 6.
- Fill 2..9 with abort_i in cycle 4:
  -> writes to 2, 3, 4 only; done_o in cycle 5 with aborted_o = 1; xfer_cnt_o = 3.
- rst_ni low in cycle 2 of a spill 1..8:
  -> all enables drop immediately; no done_o; req_ready_o = 1 after reset; a new request is then accepted normally.

Source files
------------

// File: rtl/ibex_l2_rf_xfer_pkg.sv
// Shared types and helpers for the L2 register-file transfer engine.
package ibex_l2_rf_xfer_pkg;

  localparam int unsigned L2RegAddrW = 5;

  typedef enum logic {
    L2_XFER_SPILL = 1'b0,
    L2_XFER_FILL  = 1'b1
  } l2_xfer_dir_e;

  typedef enum logic [1:0] {
    L2X_IDLE,
    L2X_XFER,
    L2X_DONE
  } l2_xfer_state_e;

  // Register 0 is never stored in L2, so a range touching it is rejected.
  function automatic logic l2_range_invalid(input logic [L2RegAddrW-1:0] first,
                                            input logic [L2RegAddrW-1:0] last,
                                            input int unsigned           num_words);
    return (first == '0) || (last == '0) || (first > last) ||
           (32'(last) >= num_words);
  endfunction

endpackage

// File: rtl/ibex_l2_rf_xfer_if.sv
// Request, status, core RF side port and L2 port of the transfer engine.
interface ibex_l2_rf_xfer_if #(
  parameter int unsigned DataWidth = 32
);
  import ibex_l2_rf_xfer_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_dir_i;
  logic [L2RegAddrW-1:0] req_first_i;
  logic [L2RegAddrW-1:0] req_last_i;
  logic                  stall_i;
  logic                  abort_i;

  logic [L2RegAddrW-1:0] rf_raddr_o;
  logic [DataWidth-1:0]  rf_rdata_i;
  logic [L2RegAddrW-1:0] rf_waddr_o;
  logic [DataWidth-1:0]  rf_wdata_o;
  logic                  rf_we_o;

  logic [L2RegAddrW-1:0] l2_addr_o;
  logic [DataWidth-1:0]  l2_wdata_o;
  logic [DataWidth-1:0]  l2_rdata_i;
  logic                  l2_we_o;

  logic                  done_o;
  logic                  err_o;
  logic                  aborted_o;
  logic [L2RegAddrW-1:0] xfer_cnt_o;

  // Engine side.
  modport slave (
    input  req_valid_i, req_dir_i, req_first_i, req_last_i, stall_i, abort_i,
           rf_rdata_i, l2_rdata_i,
    output req_ready_o, rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           l2_addr_o, l2_wdata_o, l2_we_o, done_o, err_o, aborted_o, xfer_cnt_o
  );

  // Context control plus the two register files.
  modport master (
    output req_valid_i, req_dir_i, req_first_i, req_last_i, stall_i, abort_i,
           rf_rdata_i, l2_rdata_i,
    input  req_ready_o, rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
           l2_addr_o, l2_wdata_o, l2_we_o, done_o, err_o, aborted_o, xfer_cnt_o
  );

endinterface

// File: rtl/ibex_l2_rf_xfer.sv
// Moves a contiguous register range between the core RF and the L2 RF,
// one register per cycle, with stall, abort and a one-cycle done pulse.
module ibex_l2_rf_xfer
  import ibex_l2_rf_xfer_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 28
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ibex_l2_rf_xfer_if.slave  bus
);

  localparam logic [1:0] StIdle = L2X_IDLE;
  localparam logic [1:0] StXfer = L2X_XFER;
  localparam logic [1:0] StDone = L2X_DONE;

  logic [1:0]            state_q;
  logic [L2RegAddrW-1:0] idx_q, last_q, cnt_q;
  l2_xfer_dir_e          dir_q;
  logic                  err_q, aborted_q;

  logic                  in_xfer, xfer_act, spill_act, fill_act;
  logic                  req_bad;
  logic [DataWidth-1:0]  l2_wdata, rf_wdata;

  assign req_bad = l2_range_invalid(bus.req_first_i, bus.req_last_i, NumWords);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= L2_XFER_SPILL;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid_i) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            if (req_bad) begin
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= bus.req_first_i;
              last_q  <= bus.req_last_i;
              dir_q   <= l2_xfer_dir_e'(bus.req_dir_i);
              state_q <= StXfer;
            end
          end
        end
        StXfer: begin
          // Abort wins over stall; a stalled cycle simply holds idx.
          if (bus.abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else if (!bus.stall_i) begin
            cnt_q <= cnt_q + 5'd1;
            if (idx_q == last_q) state_q <= StDone;
            else                 idx_q   <= idx_q + 5'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_xfer   = (state_q == StXfer);
  assign xfer_act  = in_xfer && !bus.abort_i && !bus.stall_i;
  assign spill_act = xfer_act && (dir_q == L2_XFER_SPILL);
  assign fill_act  = xfer_act && (dir_q == L2_XFER_FILL);

  // Write data is a gated pass-through so the buses stay quiet when idle.
  assign l2_wdata = spill_act ? bus.rf_rdata_i : '0;
  assign rf_wdata = fill_act  ? bus.l2_rdata_i : '0;

  assign bus.req_ready_o = (state_q == StIdle);
  assign bus.l2_addr_o   = in_xfer ? idx_q : '0;
  assign bus.rf_raddr_o  = (in_xfer && dir_q == L2_XFER_SPILL) ? idx_q : '0;
  assign bus.rf_waddr_o  = (in_xfer && dir_q == L2_XFER_FILL)  ? idx_q : '0;
  assign bus.l2_we_o     = spill_act;
  assign bus.l2_wdata_o  = l2_wdata;
  assign bus.rf_we_o     = fill_act;
  assign bus.rf_wdata_o  = rf_wdata;
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_o       = (state_q == StDone) && err_q;
  assign bus.aborted_o   = (state_q == StDone) && aborted_q;
  assign bus.xfer_cnt_o  = cnt_q;

endmodule
